// File: rtl/cal_sweep_sequencer.sv
// Calibration sweep: drives a ladder of DAC setpoints, discards settling samples,
// then averages four ADC channels over 2^AVG_LOG2 sample edges per step.
module cal_sweep_sequencer #(
    parameter int W              = 16,
    parameter int STEP_START     = -8000,
    parameter int STEP_SIZE      = 4000,
    parameter int N_STEPS        = 5,
    parameter int SETTLE_SAMPLES = 4,
    parameter int AVG_LOG2       = 2
) (
    input  logic                clk_12mhz,
    input  logic                rst,
    input  logic                sample_clk,
    input  logic signed [W-1:0] sample_adc0,
    input  logic signed [W-1:0] sample_adc1,
    input  logic signed [W-1:0] sample_adc2,
    input  logic signed [W-1:0] sample_adc3,
    input  logic                start,
    input  logic                abort,
    output logic signed [W-1:0] force_dac_output,
    output logic                busy,
    output logic                done,
    output logic                res_valid,
    output logic [7:0]          res_step,
    output logic signed [W-1:0] res_dac,
    output logic signed [W-1:0] res_avg0,
    output logic signed [W-1:0] res_avg1,
    output logic signed [W-1:0] res_avg2,
    output logic signed [W-1:0] res_avg3
);
    localparam int                AW          = W + AVG_LOG2;
    localparam logic [15:0]       SETTLE_LAST = 16'(SETTLE_SAMPLES - 1);
    localparam logic [15:0]       AVG_LAST    = 16'((1 << AVG_LOG2) - 1);
    localparam logic [7:0]        STEP_LAST   = 8'(N_STEPS - 1);
    localparam logic signed [W-1:0] START_V   = W'(STEP_START);
    localparam logic signed [W-1:0] SIZE_V    = W'(STEP_SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_ACCUM,
        S_EMIT,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_sclk_q;
    logic                  w_edge;
    logic [7:0]            r_step;
    logic signed [W-1:0]   r_setpoint;
    logic signed [W-1:0]   w_drive;
    logic [15:0]           r_cnt;
    logic signed [W-1:0]   w_adc     [4];
    logic signed [AW-1:0]  r_acc     [4];
    logic signed [AW-1:0]  w_acc_nxt [4];
    logic [7:0]            r_res_step;
    logic signed [W-1:0]   r_res_dac;
    logic signed [W-1:0]   r_res_avg [4];

    assign w_edge   = sample_clk & ~r_sclk_q;
    // Zero would mean passthrough to the pmod, so step it to 1 on the wire only.
    assign w_drive  = (r_setpoint == '0) ? W'(1) : r_setpoint;
    assign w_adc[0] = sample_adc0;
    assign w_adc[1] = sample_adc1;
    assign w_adc[2] = sample_adc2;
    assign w_adc[3] = sample_adc3;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_acc_nxt[i] = r_acc[i] + AW'(w_adc[i]);
        end
    end

    always_ff @(posedge clk_12mhz) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        busy             = 1'b0;
        done             = 1'b0;
        res_valid        = 1'b0;
        force_dac_output = '0;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) w_state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                busy             = 1'b1;
                force_dac_output = w_drive;
                if (abort)                                w_state_nxt = S_IDLE;
                else if (w_edge && r_cnt == SETTLE_LAST)  w_state_nxt = S_ACCUM;
            end
            S_ACCUM: begin
                busy             = 1'b1;
                force_dac_output = w_drive;
                if (abort)                                w_state_nxt = S_IDLE;
                else if (w_edge && r_cnt == AVG_LAST)     w_state_nxt = S_EMIT;
            end
            S_EMIT: begin
                busy             = 1'b1;
                force_dac_output = w_drive;
                res_valid        = !abort;
                if (abort)                                w_state_nxt = S_IDLE;
                else if (r_step == STEP_LAST)             w_state_nxt = S_DONE;
                else                                      w_state_nxt = S_SETTLE;
            end
            S_DONE: begin
                done        = !abort;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_12mhz) begin
        if (rst) begin
            r_sclk_q   <= 1'b0;
            r_step     <= '0;
            r_setpoint <= '0;
            r_cnt      <= '0;
            r_res_step <= '0;
            r_res_dac  <= '0;
            for (int i = 0; i < 4; i++) begin
                r_acc[i]     <= '0;
                r_res_avg[i] <= '0;
            end
        end else begin
            r_sclk_q <= sample_clk;
            case (r_state)
                S_IDLE: begin
                    if (w_state_nxt == S_SETTLE) begin
                        r_step     <= '0;
                        r_setpoint <= START_V;
                        r_cnt      <= '0;
                        for (int i = 0; i < 4; i++) r_acc[i] <= '0;
                    end
                end
                S_SETTLE: begin
                    if (w_edge) r_cnt <= (r_cnt == SETTLE_LAST) ? '0 : r_cnt + 16'd1;
                end
                S_ACCUM: begin
                    if (w_edge) begin
                        r_cnt <= r_cnt + 16'd1;
                        for (int i = 0; i < 4; i++) r_acc[i] <= w_acc_nxt[i];
                    end
                    // Capture the result on the final edge so it is stable throughout EMIT.
                    if (w_state_nxt == S_EMIT) begin
                        r_res_step <= r_step;
                        r_res_dac  <= w_drive;
                        for (int i = 0; i < 4; i++) r_res_avg[i] <= W'(w_acc_nxt[i] >>> AVG_LOG2);
                    end
                end
                S_EMIT: begin
                    if (w_state_nxt == S_SETTLE) begin
                        r_step     <= r_step + 8'd1;
                        r_setpoint <= r_setpoint + SIZE_V;
                        r_cnt      <= '0;
                        for (int i = 0; i < 4; i++) r_acc[i] <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_step = r_res_step;
    assign res_dac  = r_res_dac;
    assign res_avg0 = r_res_avg[0];
    assign res_avg1 = r_res_avg[1];
    assign res_avg2 = r_res_avg[2];
    assign res_avg3 = r_res_avg[3];

endmodule

// File: tb/tb_cal_sweep_sequencer.sv
// Directed bench for cal_sweep_sequencer: default-parameter instance plus a wrap-parameter instance.
module tb_cal_sweep_sequencer;
    logic clk_12mhz = 1'b0;
    always #5 clk_12mhz = ~clk_12mhz;

    logic               rst = 1'b1, sample_clk = 1'b0, start = 1'b0, abort = 1'b0, start2 = 1'b0;
    logic signed [15:0] adc0 = '0, adc1 = '0, adc2 = '0, adc3 = '0;

    logic signed [15:0] force_dac_output, res_dac, res_avg0, res_avg1, res_avg2, res_avg3;
    logic               busy, done, res_valid;
    logic [7:0]         res_step;
    logic signed [15:0] force2, res_dac2, ravg2_0, ravg2_1, ravg2_2, ravg2_3;
    logic               busy2, done2, res_valid2;
    logic [7:0]         res_step2;

    int errors = 0;
    int checks = 0;

    cal_sweep_sequencer dut (
        .clk_12mhz(clk_12mhz), .rst(rst), .sample_clk(sample_clk),
        .sample_adc0(adc0), .sample_adc1(adc1), .sample_adc2(adc2), .sample_adc3(adc3),
        .start(start), .abort(abort), .force_dac_output(force_dac_output),
        .busy(busy), .done(done), .res_valid(res_valid), .res_step(res_step), .res_dac(res_dac),
        .res_avg0(res_avg0), .res_avg1(res_avg1), .res_avg2(res_avg2), .res_avg3(res_avg3)
    );

    cal_sweep_sequencer #(.STEP_START(32000), .STEP_SIZE(1000)) dut_wrap (
        .clk_12mhz(clk_12mhz), .rst(rst), .sample_clk(sample_clk),
        .sample_adc0(adc0), .sample_adc1(adc1), .sample_adc2(adc2), .sample_adc3(adc3),
        .start(start2), .abort(abort), .force_dac_output(force2),
        .busy(busy2), .done(done2), .res_valid(res_valid2), .res_step(res_step2), .res_dac(res_dac2),
        .res_avg0(ravg2_0), .res_avg1(ravg2_1), .res_avg2(ravg2_2), .res_avg3(ravg2_3)
    );

    // Record every result record and done pulse of the main instance.
    logic signed [15:0] q_dac[$], q_a0[$], q_a1[$], q_a2[$], q_a3[$];
    logic [7:0]         q_step[$];
    int                 done_cnt = 0;

    always @(negedge clk_12mhz) begin
        if (res_valid) begin
            q_dac.push_back(res_dac);   q_step.push_back(res_step);
            q_a0.push_back(res_avg0);   q_a1.push_back(res_avg1);
            q_a2.push_back(res_avg2);   q_a3.push_back(res_avg3);
        end
        if (done) done_cnt++;
    end

    task automatic clear_log();
        q_dac.delete(); q_step.delete(); q_a0.delete(); q_a1.delete(); q_a2.delete(); q_a3.delete();
        done_cnt = 0;
    endtask

    task automatic pulse(input logic signed [15:0] v0, v1, v2, v3);
        @(negedge clk_12mhz);
        adc0 = v0; adc1 = v1; adc2 = v2; adc3 = v3;
        sample_clk = 1'b1;
        @(negedge clk_12mhz);
        sample_clk = 1'b0;
        @(negedge clk_12mhz);
    endtask

    task automatic run_step(input logic signed [15:0] s0, v0, v1, v2, v3);
        repeat (4) pulse(s0, v1, v2, v3);
        repeat (4) pulse(v0, v1, v2, v3);
    endtask

    task automatic kick();
        @(negedge clk_12mhz); start = 1'b1;
        @(negedge clk_12mhz); start = 1'b0;
    endtask

    task automatic do_abort();
        @(negedge clk_12mhz); abort = 1'b1;
        @(negedge clk_12mhz); abort = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk_12mhz);
        checks++; if (force_dac_output !== 16'sd0) begin errors++; $display("FAIL reset_force got %0d want 0", force_dac_output); end
        checks++; if ({busy, done, res_valid} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {busy, done, res_valid}); end
        checks++; if (res_step !== 8'd0 || res_dac !== 16'sd0) begin errors++; $display("FAIL reset_res got step=%0d dac=%0d want 0/0", res_step, res_dac); end
        @(negedge clk_12mhz); rst = 1'b0;
        @(negedge clk_12mhz);
    endtask

    task automatic test_basic_sweep();
        logic signed [15:0] exp_dac[5];
        exp_dac = '{-16'sd8000, -16'sd4000, 16'sd1, 16'sd4000, 16'sd8000};
        clear_log();
        kick();
        checks++; if (busy !== 1'b1 || force_dac_output !== -16'sd8000) begin errors++; $display("FAIL start_latency got busy=%0b force=%0d want 1/-8000", busy, force_dac_output); end
        for (int i = 0; i < 5; i++) begin
            run_step(16'sd100, 16'sd100, -16'sd100, 16'sd0, 16'sd32767);
            if (i < 4) begin
                checks++; if (force_dac_output !== exp_dac[i+1]) begin errors++; $display("FAIL next_setpoint%0d got %0d want %0d", i+1, force_dac_output, exp_dac[i+1]); end
            end else begin
                checks++; if (done !== 1'b1 || busy !== 1'b0 || force_dac_output !== 16'sd0) begin errors++; $display("FAIL done_cycle got done=%0b busy=%0b force=%0d want 1/0/0", done, busy, force_dac_output); end
            end
        end
        repeat (3) @(negedge clk_12mhz);
        checks++; if (q_dac.size() != 5) begin errors++; $display("FAIL basic_count got %0d want 5", q_dac.size()); end
        for (int i = 0; i < 5 && i < q_dac.size(); i++) begin
            checks++; if (q_dac[i] !== exp_dac[i] || q_step[i] !== 8'(i)) begin errors++; $display("FAIL basic_rec%0d got dac=%0d step=%0d want %0d/%0d", i, q_dac[i], q_step[i], exp_dac[i], i); end
            checks++; if (q_a0[i] !== 16'sd100 || q_a1[i] !== -16'sd100 || q_a2[i] !== 16'sd0 || q_a3[i] !== 16'sd32767) begin
                errors++; $display("FAIL basic_avg%0d got %0d,%0d,%0d,%0d want 100,-100,0,32767", i, q_a0[i], q_a1[i], q_a2[i], q_a3[i]);
            end
        end
        checks++; if (done_cnt != 1 || busy !== 1'b0 || force_dac_output !== 16'sd0) begin errors++; $display("FAIL basic_end got done_cnt=%0d busy=%0b force=%0d want 1/0/0", done_cnt, busy, force_dac_output); end
    endtask

    task automatic test_averaging();
        clear_log();
        kick();
        repeat (4) pulse(16'sd0, 16'sd0, 16'sd0, 16'sd0);
        pulse(16'sd1, 16'sd0, 16'sd0, 16'sd0); pulse(16'sd2, 16'sd0, 16'sd0, 16'sd0);
        pulse(16'sd3, 16'sd0, 16'sd0, 16'sd0); pulse(16'sd3, 16'sd0, 16'sd0, 16'sd0);
        repeat (4) pulse(16'sd0, 16'sd0, 16'sd0, 16'sd0);
        pulse(-16'sd1, 16'sd0, 16'sd0, 16'sd0);
        repeat (3) pulse(-16'sd2, 16'sd0, 16'sd0, 16'sd0);
        repeat (2) @(negedge clk_12mhz);
        checks++; if (q_a0.size() != 2) begin errors++; $display("FAIL avg_count got %0d want 2", q_a0.size()); end
        if (q_a0.size() == 2) begin
            checks++; if (q_a0[0] !== 16'sd2) begin errors++; $display("FAIL avg_pos got %0d want 2", q_a0[0]); end
            checks++; if (q_a0[1] !== -16'sd2) begin errors++; $display("FAIL avg_neg_floor got %0d want -2", q_a0[1]); end
        end
        do_abort();
    endtask

    task automatic test_settle_discard();
        clear_log();
        kick();
        run_step(16'sd30000, 16'sd0, 16'sd0, 16'sd0, 16'sd0);
        repeat (2) @(negedge clk_12mhz);
        checks++; if (q_a0.size() != 1 || res_avg0 !== 16'sd0) begin errors++; $display("FAIL settle_discard got n=%0d avg0=%0d want 1/0", q_a0.size(), res_avg0); end
        do_abort();
    endtask

    task automatic test_abort();
        clear_log();
        kick();
        repeat (2) run_step(16'sd10, 16'sd10, 16'sd10, 16'sd10, 16'sd10);
        repeat (4) pulse(16'sd10, 16'sd10, 16'sd10, 16'sd10);
        repeat (2) pulse(16'sd10, 16'sd10, 16'sd10, 16'sd10);
        do_abort();
        checks++; if (busy !== 1'b0 || force_dac_output !== 16'sd0) begin errors++; $display("FAIL abort_idle got busy=%0b force=%0d want 0/0", busy, force_dac_output); end
        repeat (10) pulse(16'sd10, 16'sd10, 16'sd10, 16'sd10);
        repeat (2) @(negedge clk_12mhz);
        checks++; if (q_dac.size() != 2 || done_cnt != 0) begin errors++; $display("FAIL abort_quiet got results=%0d done=%0d want 2/0", q_dac.size(), done_cnt); end
        checks++; if (res_step !== 8'd1 || res_dac !== -16'sd4000) begin errors++; $display("FAIL abort_hold got step=%0d dac=%0d want 1/-4000", res_step, res_dac); end
    endtask

    task automatic test_requests();
        clear_log();
        kick();
        run_step(16'sd7, 16'sd7, 16'sd7, 16'sd7, 16'sd7);
        pulse(16'sd7, 16'sd7, 16'sd7, 16'sd7);
        kick();
        repeat (3) pulse(16'sd7, 16'sd7, 16'sd7, 16'sd7);
        repeat (4) pulse(16'sd7, 16'sd7, 16'sd7, 16'sd7);
        repeat (3) run_step(16'sd7, 16'sd7, 16'sd7, 16'sd7, 16'sd7);
        repeat (3) @(negedge clk_12mhz);
        checks++; if (q_step.size() != 5 || done_cnt != 1) begin errors++; $display("FAIL ignored_start got results=%0d done=%0d want 5/1", q_step.size(), done_cnt); end
        for (int i = 0; i < 5 && i < q_step.size(); i++) begin
            checks++; if (q_step[i] !== 8'(i)) begin errors++; $display("FAIL ignored_start_step%0d got %0d want %0d", i, q_step[i], i); end
        end
        @(negedge clk_12mhz); start = 1'b1; abort = 1'b1;
        @(negedge clk_12mhz); start = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b0 || force_dac_output !== 16'sd0) begin errors++; $display("FAIL start_abort got busy=%0b force=%0d want 0/0", busy, force_dac_output); end
        repeat (3) @(negedge clk_12mhz);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_abort_later got busy=%0b want 0", busy); end
    endtask

    task automatic test_wrap();
        @(negedge clk_12mhz); start2 = 1'b1;
        @(negedge clk_12mhz); start2 = 1'b0;
        checks++; if (busy2 !== 1'b1 || force2 !== 16'sd32000) begin errors++; $display("FAIL wrap_start got busy=%0b force=%0d want 1/32000", busy2, force2); end
        run_step(16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0);
        checks++; if (force2 !== -16'sd32536) begin errors++; $display("FAIL wrap_step1 got %0d want -32536", force2); end
        checks++; if (res_dac2 !== 16'sd32000 || res_step2 !== 8'd0) begin errors++; $display("FAIL wrap_res got dac=%0d step=%0d want 32000/0", res_dac2, res_step2); end
    endtask

    task automatic test_reset_midsweep();
        kick();
        repeat (2) run_step(16'sd5, 16'sd5, 16'sd6, 16'sd7, 16'sd8);
        repeat (2) pulse(16'sd5, 16'sd5, 16'sd6, 16'sd7);
        checks++; if (res_step !== 8'd1 || res_dac !== -16'sd4000 || res_avg3 !== 16'sd8) begin errors++; $display("FAIL pre_reset got step=%0d dac=%0d avg3=%0d want 1/-4000/8", res_step, res_dac, res_avg3); end
        @(negedge clk_12mhz); rst = 1'b1;
        @(negedge clk_12mhz); rst = 1'b0;
        checks++; if (force_dac_output !== 16'sd0 || {busy, done, res_valid} !== 3'b000) begin errors++; $display("FAIL mid_reset_ctl got force=%0d flags=%b want 0/000", force_dac_output, {busy, done, res_valid}); end
        checks++; if (res_step !== 8'd0 || res_dac !== 16'sd0) begin errors++; $display("FAIL mid_reset_res got step=%0d dac=%0d want 0/0", res_step, res_dac); end
        checks++; if ({res_avg0, res_avg1, res_avg2, res_avg3} !== 64'd0) begin errors++; $display("FAIL mid_reset_avg got %0d,%0d,%0d,%0d want 0", res_avg0, res_avg1, res_avg2, res_avg3); end
        checks++; if (force2 !== 16'sd0 || busy2 !== 1'b0) begin errors++; $display("FAIL mid_reset_wrap got force=%0d busy=%0b want 0/0", force2, busy2); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic_sweep();
        test_averaging();
        test_settle_discard();
        test_abort();
        test_requests();
        test_wrap();
        test_reset_midsweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
